// File: rtl/arrow_lane_engine.sv
// ---------------------------------------------------------------------------
// arrow_lane_engine
//
// Purpose:
//   Multi-lane arrow engine for the DDR playfield. Each lane owns SLOTS arrow
//   slots (valid bit + y position). Arrows spawn at SPAWN_Y, scroll up by
//   SPEED pixels on every frame pulse, are judged against a window around
//   TARGET_Y when the lane button is pressed, and are retired as misses once
//   they scroll past the bottom of that window. The block also produces a
//   registered per-lane pixel mask for the VGA compositor.
//
// Ports:
//   clk_i          in   pixel clock
//   rst_ni         in   asynchronous active-low reset (clears every arrow)
//   frame_i        in   one-cycle pulse per frame, at start of blanking
//   sx_i, sy_i     in   current pixel coordinates (CORDW bits)
//   spawn_i        in   per-lane spawn request
//   spawn_ready_o  out  per-lane "at least one free slot" (state only)
//   press_i        in   per-lane debounced one-cycle press pulse
//   arrow_o        out  per-lane pixel mask, one cycle after sx_i/sy_i
//   hit_o          out  per-lane one-cycle hit pulse
//   miss_o         out  per-lane one-cycle miss pulse
//
// Configuration macro:
//   STRAY_PRESS_MISS_EN - when defined, a press that finds no arrow in the
//   judgment window also pulses miss_o for that lane. Undefined by default,
//   in which case stray presses are ignored.
// ---------------------------------------------------------------------------
module arrow_lane_engine #(
  parameter int CORDW      = 10,
  parameter int LANES      = 4,
  parameter int SLOTS      = 4,
  parameter int LANE_X0    = 160,
  parameter int LANE_PITCH = 64,
  parameter int ARROW_SIZE = 31,
  parameter int SPAWN_Y    = 448,
  parameter int TARGET_Y   = 32,
  parameter int HIT_WIN    = 8,
  parameter int SPEED      = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             frame_i,
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  input  logic [LANES-1:0] spawn_i,
  output logic [LANES-1:0] spawn_ready_o,
  input  logic [LANES-1:0] press_i,
  output logic [LANES-1:0] arrow_o,
  output logic [LANES-1:0] hit_o,
  output logic [LANES-1:0] miss_o
);

  localparam logic [CORDW-1:0] WIN_LO    = CORDW'(TARGET_Y - HIT_WIN);
  localparam logic [CORDW-1:0] WIN_HI    = CORDW'(TARGET_Y + HIT_WIN);
  localparam logic [CORDW-1:0] SPAWN_POS = CORDW'(SPAWN_Y);
  localparam logic [CORDW-1:0] STEP      = CORDW'(SPEED);
  // Box extent is kept one bit wider so right/bottom edges never wrap.
  localparam logic [CORDW:0]   BOX       = (CORDW+1)'(ARROW_SIZE);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam logic [CORDW:0] X_LO = (CORDW+1)'(LANE_X0 + l * LANE_PITCH);
    localparam logic [CORDW:0] X_HI = X_LO + BOX;

    logic [SLOTS-1:0] valid_q;
    logic [SLOTS-1:0] valid_d;
    logic [CORDW-1:0] y_q [SLOTS];
    logic [CORDW-1:0] y_d [SLOTS];

    logic [SLOTS-1:0] free_oh;
    logic             free_seen;
    logic [SLOTS-1:0] spawn_oh;
    logic [SLOTS-1:0] hit_oh;
    logic             hit_found;
    logic [CORDW-1:0] best_y;
    logic [SLOTS-1:0] slot_miss;
    logic             miss_d;
    logic [SLOTS-1:0] on_pixel;
    logic             in_x;

    logic             hit_q;
    logic             miss_q;
    logic             arrow_q;

    // Lowest-index free slot, and the judgment pick: minimum y among valid
    // slots inside the window (pre-scroll y). The strict '<' keeps the
    // lowest index on ties.
    always_comb begin
      free_oh   = '0;
      free_seen = 1'b0;
      hit_oh    = '0;
      hit_found = 1'b0;
      best_y    = '0;
      for (int s = 0; s < SLOTS; s++) begin
        if (!valid_q[s] && !free_seen) begin
          free_oh[s] = 1'b1;
          free_seen  = 1'b1;
        end
        if (press_i[l] && valid_q[s] && (y_q[s] >= WIN_LO) && (y_q[s] <= WIN_HI)
            && (!hit_found || (y_q[s] < best_y))) begin
          hit_oh    = '0;
          hit_oh[s] = 1'b1;
          hit_found = 1'b1;
          best_y    = y_q[s];
        end
      end
    end

    assign spawn_oh = free_oh & {SLOTS{spawn_i[l]}};

    // Slot update priority: a hit clears the slot (so it is never scrolled
    // or missed), a spawn loads SPAWN_Y exactly, otherwise a frame scrolls
    // the arrow and retires it if it dropped below the window. A hit slot
    // is valid and a spawn slot is free, so they can never coincide.
    always_comb begin
      slot_miss = '0;
      for (int s = 0; s < SLOTS; s++) begin
        valid_d[s] = valid_q[s];
        y_d[s]     = y_q[s];
        if (hit_oh[s]) begin
          valid_d[s] = 1'b0;
        end else if (spawn_oh[s]) begin
          valid_d[s] = 1'b1;
          y_d[s]     = SPAWN_POS;
        end else if (frame_i && valid_q[s]) begin
          y_d[s] = y_q[s] - STEP;
          if ((y_q[s] - STEP) < WIN_LO) begin
            valid_d[s]   = 1'b0;
            slot_miss[s] = 1'b1;
          end
        end
      end
`ifdef STRAY_PRESS_MISS_EN
      miss_d = (|slot_miss) | (press_i[l] & ~hit_found);
`else
      miss_d = |slot_miss;
`endif
    end

    // Pixel test against every live slot of this lane, bounds at CORDW+1.
    always_comb begin
      in_x = ({1'b0, sx_i} >= X_LO) && ({1'b0, sx_i} <= X_HI);
      for (int s = 0; s < SLOTS; s++) begin
        on_pixel[s] = valid_q[s]
                      && ({1'b0, sy_i} >= {1'b0, y_q[s]})
                      && ({1'b0, sy_i} <= ({1'b0, y_q[s]} + BOX));
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int s = 0; s < SLOTS; s++) y_q[s] <= '0;
        hit_q   <= 1'b0;
        miss_q  <= 1'b0;
        arrow_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
        for (int s = 0; s < SLOTS; s++) y_q[s] <= y_d[s];
        hit_q   <= hit_found;
        miss_q  <= miss_d;
        arrow_q <= in_x & (|on_pixel);
      end
    end

    assign spawn_ready_o[l] = ~&valid_q;
    assign hit_o[l]         = hit_q;
    assign miss_o[l]        = miss_q;
    assign arrow_o[l]       = arrow_q;
  end

endmodule

// File: tb/tb_arrow_lane_engine.sv
// ---------------------------------------------------------------------------
// tb_arrow_lane_engine
//
// Self-checking bench for arrow_lane_engine. A behavioural model of the lane
// rules (integer y positions per slot) predicts hit/miss/pixel/ready each
// cycle; directed scenarios add fixed expected values from the playfield
// geometry, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_arrow_lane_engine;

  localparam int LANES = 4;
  localparam int SLOTS = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       frame_i = 1'b0;
  logic [9:0] sx_i = '0;
  logic [9:0] sy_i = '0;
  logic [3:0] spawn_i = '0;
  logic [3:0] press_i = '0;
  logic [3:0] spawn_ready_o;
  logic [3:0] arrow_o;
  logic [3:0] hit_o;
  logic [3:0] miss_o;

  int checks = 0;
  int errors = 0;

  // Model state: per slot, live flag and integer y.
  bit m_live [LANES][SLOTS];
  int m_y    [LANES][SLOTS];

  arrow_lane_engine dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .frame_i       (frame_i),
    .sx_i          (sx_i),
    .sy_i          (sy_i),
    .spawn_i       (spawn_i),
    .spawn_ready_o (spawn_ready_o),
    .press_i       (press_i),
    .arrow_o       (arrow_o),
    .hit_o         (hit_o),
    .miss_o        (miss_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void modelClear();
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SLOTS; s++) begin
        m_live[l][s] = 1'b0;
        m_y[l][s]    = 0;
      end
  endfunction

  function automatic logic [3:0] modelReady();
    logic [3:0] r = '0;
    for (int l = 0; l < LANES; l++)
      for (int s = 0; s < SLOTS; s++)
        if (!m_live[l][s]) r[l] = 1'b1;
    return r;
  endfunction

  // One clock of the game rules: judge on the old y, then spawn, then scroll.
  function automatic void modelStep(input bit fr, input logic [3:0] sp, input logic [3:0] pr,
                                    input int sx, input int sy,
                                    output logic [3:0] e_hit, output logic [3:0] e_miss,
                                    output logic [3:0] e_arrow);
    e_hit = '0; e_miss = '0; e_arrow = '0;
    for (int l = 0; l < LANES; l++) begin
      int xl = 160 + l * 64;
      int pick = -1;
      int fs = -1;
      for (int s = 0; s < SLOTS; s++)
        if (m_live[l][s] && sx >= xl && sx <= xl + 31 && sy >= m_y[l][s] && sy <= m_y[l][s] + 31)
          e_arrow[l] = 1'b1;
      if (pr[l])
        for (int s = 0; s < SLOTS; s++)
          if (m_live[l][s] && m_y[l][s] >= 24 && m_y[l][s] <= 40 &&
              (pick < 0 || m_y[l][s] < m_y[l][pick]))
            pick = s;
      e_hit[l] = (pick >= 0);
`ifdef STRAY_PRESS_MISS_EN
      if (pr[l] && pick < 0) e_miss[l] = 1'b1;
`endif
      for (int s = 0; s < SLOTS; s++)
        if (!m_live[l][s] && fs < 0) fs = s;
      for (int s = 0; s < SLOTS; s++) begin
        if (s == pick) begin
          m_live[l][s] = 1'b0;
        end else if (sp[l] && s == fs) begin
          m_live[l][s] = 1'b1;
          m_y[l][s]    = 448;
        end else if (fr && m_live[l][s]) begin
          m_y[l][s] -= 4;
          if (m_y[l][s] < 24) begin
            m_live[l][s] = 1'b0;
            e_miss[l]    = 1'b1;
          end
        end
      end
    end
  endfunction

  // Drive one cycle of inputs, advance the model, check every output.
  task automatic applyStimulus(input bit fr, input logic [3:0] sp, input logic [3:0] pr,
                               input int sx, input int sy);
    logic [3:0] e_hit, e_miss, e_arrow, e_ready;
    @(negedge clk_i);
    frame_i = fr; spawn_i = sp; press_i = pr;
    sx_i = 10'(sx); sy_i = 10'(sy);
    modelStep(fr, sp, pr, sx, sy, e_hit, e_miss, e_arrow);
    e_ready = modelReady();
    @(posedge clk_i);
    #1;
    checkOutput("hit", 32'(hit_o), 32'(e_hit));
    checkOutput("miss", 32'(miss_o), 32'(e_miss));
    checkOutput("arrow", 32'(arrow_o), 32'(e_arrow));
    checkOutput("ready", 32'(spawn_ready_o), 32'(e_ready));
  endtask

  task automatic runFrames(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 4'b0000, 4'b0000, 0, 0);
  endtask

  // Reset lands mid-cycle to exercise the asynchronous path.
  task automatic applyReset();
    @(negedge clk_i);
    frame_i = 1'b0; spawn_i = '0; press_i = '0;
    #2;
    rst_ni = 1'b0;
    modelClear();
    #1;
    checkOutput("rst_arrow", 32'(arrow_o), 32'h0);
    checkOutput("rst_hit", 32'(hit_o), 32'h0);
    checkOutput("rst_miss", 32'(miss_o), 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    checkOutput("rst_ready", 32'(spawn_ready_o), 32'hF);
  endtask

  initial begin
    $display("[TB] arrow_lane_engine bench starting");
    modelClear();
    applyReset();

    // Mid-game reset discards live arrows.
    applyStimulus(1'b0, 4'b0111, 4'b0000, 0, 0);
    runFrames(5);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 160, 428);
    checkOutput("pre_rst_draw", 32'(arrow_o[0]), 32'h1);
    applyReset();
    applyStimulus(1'b0, 4'b0000, 4'b0000, 160, 428);
    checkOutput("post_rst_draw", 32'(arrow_o[0]), 32'h0);
    checkOutput("post_rst_ready", 32'(spawn_ready_o), 32'hF);

    // Pixel edges of a fresh lane-1 arrow at y=448.
    applyStimulus(1'b0, 4'b0010, 4'b0000, 0, 0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 224, 448);
    checkOutput("pix_in", 32'(arrow_o[1]), 32'h1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 256, 448);
    checkOutput("pix_right", 32'(arrow_o[1]), 32'h0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 224, 479);
    checkOutput("pix_bottom", 32'(arrow_o[1]), 32'h1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 224, 480);
    checkOutput("pix_below", 32'(arrow_o[1]), 32'h0);

    // Hit window on lane 0.
    applyReset();
    applyStimulus(1'b0, 4'b0001, 4'b0000, 0, 0);
    runFrames(101);
    applyStimulus(1'b0, 4'b0000, 4'b0001, 0, 0);
    checkOutput("early_press", 32'(hit_o[0]), 32'h0);
    runFrames(1);
    applyStimulus(1'b0, 4'b0000, 4'b0001, 0, 0);
    checkOutput("win_hit", 32'(hit_o[0]), 32'h1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 0, 0);
    checkOutput("hit_pulse_end", 32'(hit_o[0]), 32'h0);

    // Press and frame in the same cycle at y=40.
    applyStimulus(1'b0, 4'b0001, 4'b0000, 0, 0);
    runFrames(102);
    applyStimulus(1'b1, 4'b0000, 4'b0001, 0, 0);
    checkOutput("press_frame_hit", 32'(hit_o[0]), 32'h1);
    checkOutput("press_frame_nomiss", 32'(miss_o[0]), 32'h0);

    // Miss on lane 3.
    applyReset();
    applyStimulus(1'b0, 4'b1000, 4'b0000, 0, 0);
    runFrames(106);
    checkOutput("no_miss_24", 32'(miss_o[3]), 32'h0);
    runFrames(1);
    checkOutput("miss_20", 32'(miss_o[3]), 32'h1);
    checkOutput("miss_ready", 32'(spawn_ready_o[3]), 32'h1);

    // Fill lane 2 with staggered arrows (436,440,444,448), fifth is dropped.
    applyReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'b0100, 4'b0000, 0, 0);
    checkOutput("full_ready", 32'(spawn_ready_o[2]), 32'h0);
    applyStimulus(1'b0, 4'b0100, 4'b0000, 288, 479);
    checkOutput("drop_ready", 32'(spawn_ready_o[2]), 32'h0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 288, 479);
    checkOutput("full_draw", 32'(arrow_o[2]), 32'h1);
    runFrames(99);
    applyStimulus(1'b0, 4'b0000, 4'b0100, 0, 0);
    checkOutput("full_hit", 32'(hit_o[2]), 32'h1);
    checkOutput("freed_ready", 32'(spawn_ready_o[2]), 32'h1);

    // Spawn together with a frame keeps y=448 exactly.
    applyReset();
    applyStimulus(1'b1, 4'b0001, 4'b0000, 0, 0);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 160, 448);
    checkOutput("spawn_frame_top", 32'(arrow_o[0]), 32'h1);
    applyStimulus(1'b0, 4'b0000, 4'b0000, 160, 447);
    checkOutput("spawn_frame_above", 32'(arrow_o[0]), 32'h0);

    // Stray press on an empty lane.
    applyStimulus(1'b0, 4'b0000, 4'b0010, 0, 0);
    checkOutput("stray_hit", 32'(hit_o[1]), 32'h0);
`ifdef STRAY_PRESS_MISS_EN
    checkOutput("stray_miss", 32'(miss_o[1]), 32'h1);
`else
    checkOutput("stray_miss", 32'(miss_o[1]), 32'h0);
`endif

    // Randomized play against the model.
    applyReset();
    for (int i = 0; i < 4000; i++) begin
      bit fr;
      logic [3:0] sp, pr;
      fr = ($urandom_range(0, 1) == 1);
      for (int l = 0; l < LANES; l++) begin
        sp[l] = ($urandom_range(0, 19) == 0);
        pr[l] = ($urandom_range(0, 5) == 0);
      end
      applyStimulus(fr, sp, pr, int'($urandom_range(150, 420)), int'($urandom_range(0, 511)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
